// File: rtl/tt_pin_host.sv
// tt_pin_host: host-side initiator for the Tiny Tapeout pin interface.
// A command byte accepted on the cmd stream is placed on ui_in and then
// handed to the project with a 4-phase req/ack handshake: req is
// uio_in[0] and ack is uio_out[1], which only counts while uio_oe[1] is
// set. The byte the project drives on uo_out while ack is high is
// returned on the rsp stream. Either wait for ack is bounded by a
// timeout, which aborts the transaction with a one-cycle err_timeout
// pulse.
module tt_pin_host #(
    parameter int SETUP_CYC   = 2,
    parameter int TIMEOUT_CYC = 1024,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       err_timeout,
    output logic       busy,
    output logic [7:0] ui_in,
    output logic [7:0] uio_in,
    input  logic [7:0] uo_out,
    input  logic [7:0] uio_out,
    input  logic [7:0] uio_oe
);

    // The counter serves both the setup delay (at most 15) and the
    // timeout, so it is sized for whichever needs more bits.
    localparam int TO_W  = $clog2(TIMEOUT_CYC);
    localparam int CNT_W = (TO_W > 4) ? TO_W : 4;
    localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        WAIT_ACK,
        WAIT_REL,
        RSP
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [7:0]       ui_q;
    logic [7:0]       ui_nxt;
    logic [7:0]       rsp_q;
    logic [7:0]       rsp_nxt;
    logic             req_q;
    logic             req_nxt;
    logic             rsp_valid_q;
    logic             rsp_valid_nxt;
    logic             err_q;
    logic             err_nxt;

    logic [SYNC_STAGES-1:0] ack_sync;
    logic                   ack_raw;
    logic                   ack_s;

    // Only bit 1 of the bidir bus matters here; the remaining bits are
    // folded into a sink so they are visibly intentional.
    logic unused_pins;

    // A bidir pin the project is not driving reads as 0, so a floating
    // ack can never complete a handshake.
    assign ack_raw     = uio_out[1] & uio_oe[1];
    assign ack_s       = ack_sync[SYNC_STAGES-1];
    assign unused_pins = ^{uio_out[7:2], uio_out[0], uio_oe[7:2], uio_oe[0]};

    // Shift the asynchronous ack through the synchronizer chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack_raw};
        end
    end

    // State register plus every registered pin and stream output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            ui_q        <= '0;
            rsp_q       <= '0;
            req_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            ui_q        <= ui_nxt;
            rsp_q       <= rsp_nxt;
            req_q       <= req_nxt;
            rsp_valid_q <= rsp_valid_nxt;
            err_q       <= err_nxt;
        end
    end

    // Next-state logic for the handshake sequence and both timeouts.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        ui_nxt        = ui_q;
        rsp_nxt       = rsp_q;
        req_nxt       = req_q;
        rsp_valid_nxt = rsp_valid_q;
        err_nxt       = 1'b0;

        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    ui_nxt    = cmd_data;
                    cnt_nxt   = '0;
                    state_nxt = SETUP;
                end
            end

            SETUP: begin
                if (cnt == SETUP_LAST) begin
                    req_nxt   = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = WAIT_ACK;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end

            WAIT_ACK: begin
                if (ack_s) begin
                    rsp_nxt   = uo_out;
                    req_nxt   = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = WAIT_REL;
                end else if (cnt == TIMEOUT_LAST) begin
                    req_nxt   = 1'b0;
                    ui_nxt    = '0;
                    err_nxt   = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end

            WAIT_REL: begin
                if (!ack_s) begin
                    rsp_valid_nxt = 1'b1;
                    ui_nxt        = '0;
                    cnt_nxt       = '0;
                    state_nxt     = RSP;
                end else if (cnt == TIMEOUT_LAST) begin
                    // The project never released ack, so the byte it
                    // returned cannot be trusted and is thrown away.
                    ui_nxt    = '0;
                    rsp_nxt   = '0;
                    err_nxt   = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end

            RSP: begin
                if (rsp_ready) begin
                    rsp_valid_nxt = 1'b0;
                    state_nxt     = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // cmd_ready is gated by rst_n so it is low for the whole reset.
    assign cmd_ready   = rst_n & (state == IDLE);
    assign busy        = (state != IDLE);
    assign ui_in       = ui_q;
    assign uio_in      = {7'b0000000, req_q};
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_tt_pin_host.sv
// Self-checking bench for tt_pin_host: a behavioural project model sits on
// the pin side, a table of directed vectors plus random transactions is run
// against outcomes derived from the protocol rules, and an async reset in
// the middle of a transaction is exercised by hand.
module tb_tt_pin_host;

    localparam int SETUP_CYC   = 2;
    localparam int TIMEOUT_CYC = 16;
    localparam int SYNC_STAGES = 2;
    localparam int WAIT_LIMIT  = 300;

    typedef enum logic [1:0] {M_NORMAL, M_NEVER, M_NOOE, M_HOLD} ack_mode_t;

    typedef struct {
        logic [7:0] cmd;
        ack_mode_t  mode;
        int         delay;
        int         hold;
        logic       expTimeout;
        logic [7:0] expRsp;
    } vector_t;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       err_timeout;
    logic       busy;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int assertCount;
    int failCount;

    tt_pin_host #(
        .SETUP_CYC  (SETUP_CYC),
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_data   (cmd_data),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .err_timeout(err_timeout),
        .busy       (busy),
        .ui_in      (ui_in),
        .uio_in     (uio_in),
        .uo_out     (uo_out),
        .uio_out    (uio_out),
        .uio_oe     (uio_oe)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Project model: raises ack a programmable number of cycles after req,
    // drops it once req falls, and returns the inverted input byte.
    ack_mode_t  ackMode;
    int         ackDelay;
    logic       ackLevel;
    int         reqAge;
    logic [7:0] junkOut;
    logic [7:0] junkOe;

    always @(negedge clk) begin
        junkOut <= 8'($urandom);
        junkOe  <= 8'($urandom);
        if (uio_in[0]) begin
            if (!ackLevel && ackMode != M_NEVER && reqAge >= ackDelay) ackLevel <= 1'b1;
            reqAge <= reqAge + 1;
        end else begin
            reqAge <= 0;
            if (ackMode != M_HOLD) ackLevel <= 1'b0;
        end
        uio_out <= {junkOut[7:2], ackLevel, junkOut[0]};
        uio_oe  <= {junkOe[7:2], (ackMode != M_NOOE), junkOe[0]};
        uo_out  <= ackLevel ? ~ui_in : junkOut;
    end

    // Pin and stream monitor: counts req pulses, error pulses, response
    // handshakes and the setup window in front of each req.
    int         reqRises;
    int         reqLen;
    int         lastReqLen;
    int         errPulses;
    int         rspHandshakes;
    logic [7:0] lastRsp;
    int         readyViolations;
    int         pinViolations;
    logic       prevReq;
    int         setupCnt;
    int         lastSetupCnt;
    logic [7:0] setupVal;
    logic [7:0] lastSetupVal;
    logic       setupStable;
    logic       lastSetupStable;

    always @(negedge clk) begin
        if (rst_n) begin
            if (cmd_ready !== !busy) readyViolations <= readyViolations + 1;
            if (uio_in[7:1] !== 7'd0) pinViolations <= pinViolations + 1;
            if (err_timeout) errPulses <= errPulses + 1;
            if (rsp_valid && rsp_ready) begin
                rspHandshakes <= rspHandshakes + 1;
                lastRsp       <= rsp_data;
            end
            if (uio_in[0] && !prevReq) begin
                reqRises        <= reqRises + 1;
                reqLen          <= 1;
                lastSetupCnt    <= setupCnt;
                lastSetupVal    <= setupVal;
                lastSetupStable <= setupStable;
            end else if (uio_in[0]) begin
                reqLen <= reqLen + 1;
            end
            if (!uio_in[0] && prevReq) lastReqLen <= reqLen;
            prevReq <= uio_in[0];
            if (!busy) begin
                setupCnt    <= 0;
                setupStable <= 1'b1;
            end else if (!uio_in[0]) begin
                if (setupCnt == 0) setupVal <= ui_in;
                else if (ui_in !== setupVal) setupStable <= 1'b0;
                setupCnt <= setupCnt + 1;
            end
        end else begin
            prevReq <= 1'b0;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Expected outcome from the protocol rules: a project that acks and
    // releases returns ~cmd; any other behaviour ends in a timeout.
    function automatic vector_t refModel(input logic [7:0] cmd, input ack_mode_t mode,
                                         input int delay, input int hold);
        vector_t v;
        v.cmd        = cmd;
        v.mode       = mode;
        v.delay      = delay;
        v.hold       = hold;
        v.expTimeout = (mode != M_NORMAL);
        v.expRsp     = v.expTimeout ? 8'h00 : ~cmd;
        return v;
    endfunction

    // Run one command to completion and report what was observed.
    task automatic applyStimulus(input logic [7:0] cmd, input ack_mode_t mode, input int delay,
                                 input int hold, output logic [7:0] rsp, output int errD,
                                 output int rspD, output int reqD, output int holdBad);
        int n;
        int rises0;
        int err0;
        int hs0;
        logic [7:0] firstData;
        @(posedge clk);
        #1;
        ackMode   = mode;
        ackDelay  = delay;
        rsp_ready = (hold == 0);
        holdBad   = 0;
        repeat (3) @(negedge clk);
        rises0 = reqRises;
        err0   = errPulses;
        hs0    = rspHandshakes;
        n = 0;
        while (!cmd_ready && n < WAIT_LIMIT) begin
            @(negedge clk);
            n++;
        end
        checkOutput("cmd_ready_wait", cmd_ready, 1);
        cmd_data  = cmd;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        n = 0;
        while (!rsp_valid && errPulses == err0 && n < WAIT_LIMIT) begin
            @(negedge clk);
            n++;
        end
        checkOutput("completion_wait", (n < WAIT_LIMIT), 1);
        if (rsp_valid && hold > 0) begin
            firstData = rsp_data;
            repeat (hold) begin
                @(negedge clk);
                if (rsp_data !== firstData || !rsp_valid || cmd_ready || reqRises != rises0 + 1)
                    holdBad++;
            end
            @(posedge clk);
            #1;
            rsp_ready = 1'b1;
        end
        n = 0;
        while (rspHandshakes == hs0 && errPulses == err0 && n < WAIT_LIMIT) begin
            @(negedge clk);
            n++;
        end
        checkOutput("handshake_wait", (n < WAIT_LIMIT), 1);
        repeat (3) @(negedge clk);
        rsp  = lastRsp;
        errD = errPulses - err0;
        rspD = rspHandshakes - hs0;
        reqD = reqRises - rises0;
    endtask

    task automatic runVector(input string tag, input vector_t v);
        logic [7:0] rsp;
        int errD;
        int rspD;
        int reqD;
        int holdBad;
        applyStimulus(v.cmd, v.mode, v.delay, v.hold, rsp, errD, rspD, reqD, holdBad);
        checkOutput({tag, " err_pulses"}, errD, v.expTimeout ? 1 : 0);
        checkOutput({tag, " rsp_count"}, rspD, v.expTimeout ? 0 : 1);
        if (!v.expTimeout) checkOutput({tag, " rsp_data"}, rsp, v.expRsp);
        checkOutput({tag, " req_pulses"}, reqD, 1);
        checkOutput({tag, " setup_cycles"}, lastSetupCnt, SETUP_CYC);
        checkOutput({tag, " setup_value"}, lastSetupVal, v.cmd);
        checkOutput({tag, " setup_stable"}, lastSetupStable, 1);
        if (v.mode == M_NEVER || v.mode == M_NOOE)
            checkOutput({tag, " req_high_cycles"}, lastReqLen, TIMEOUT_CYC);
        checkOutput({tag, " hold_stable"}, holdBad, 0);
        checkOutput({tag, " idle_busy"}, busy, 0);
        checkOutput({tag, " idle_ui_in"}, ui_in, 0);
        checkOutput({tag, " idle_uio_in"}, uio_in, 0);
        checkOutput({tag, " idle_rsp_valid"}, rsp_valid, 0);
    endtask

    // Abort a transaction with an asynchronous reset while req is high.
    task automatic resetMidTransaction();
        int err0;
        int hs0;
        @(posedge clk);
        #1;
        ackMode   = M_NEVER;
        rsp_ready = 1'b1;
        @(negedge clk);
        checkOutput("rst_seq cmd_ready", cmd_ready, 1);
        cmd_data  = 8'h77;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("rst_seq req_high", uio_in[0], 1);
        err0 = errPulses;
        hs0  = rspHandshakes;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_seq ui_in", ui_in, 0);
        checkOutput("rst_seq uio_in", uio_in, 0);
        checkOutput("rst_seq busy", busy, 0);
        checkOutput("rst_seq cmd_ready_low", cmd_ready, 0);
        checkOutput("rst_seq err_timeout", err_timeout, 0);
        checkOutput("rst_seq rsp_valid", rsp_valid, 0);
        ackMode = M_NORMAL;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_seq idle_cmd_ready", cmd_ready, 1);
        repeat (TIMEOUT_CYC + 10) @(negedge clk);
        checkOutput("rst_seq no_error", errPulses - err0, 0);
        checkOutput("rst_seq no_response", rspHandshakes - hs0, 0);
    endtask

    vector_t vectors [10];

    initial begin
        assertCount     = 0;
        failCount       = 0;
        rst_n           = 1'b0;
        cmd_valid       = 1'b0;
        cmd_data        = 8'h00;
        rsp_ready       = 1'b0;
        ackMode         = M_NORMAL;
        ackDelay        = 3;
        ackLevel        = 1'b0;
        reqAge          = 0;
        uo_out          = 8'h00;
        uio_out         = 8'h00;
        uio_oe          = 8'h00;
        reqRises        = 0;
        reqLen          = 0;
        lastReqLen      = 0;
        errPulses       = 0;
        rspHandshakes   = 0;
        lastRsp         = 8'h00;
        readyViolations = 0;
        pinViolations   = 0;
        prevReq         = 1'b0;
        setupCnt        = 0;
        lastSetupCnt    = 0;
        setupVal        = 8'h00;
        lastSetupVal    = 8'h00;
        setupStable     = 1'b1;
        lastSetupStable = 1'b0;

        vectors[0] = '{8'h5A, M_NORMAL, 3, 0,  1'b0, 8'hA5};
        vectors[1] = '{8'h00, M_NORMAL, 3, 0,  1'b0, 8'hFF};
        vectors[2] = '{8'hFF, M_NORMAL, 3, 0,  1'b0, 8'h00};
        vectors[3] = '{8'h81, M_NORMAL, 3, 0,  1'b0, 8'h7E};
        vectors[4] = '{8'hC3, M_NORMAL, 1, 20, 1'b0, 8'h3C};
        vectors[5] = '{8'h12, M_NEVER,  0, 0,  1'b1, 8'h00};
        vectors[6] = '{8'h33, M_NORMAL, 2, 0,  1'b0, 8'hCC};
        vectors[7] = '{8'h44, M_NOOE,   2, 0,  1'b1, 8'h00};
        vectors[8] = '{8'h9C, M_HOLD,   2, 0,  1'b1, 8'h00};
        vectors[9] = '{8'h6E, M_NORMAL, 0, 0,  1'b0, 8'h91};

        #12;
        checkOutput("reset ui_in", ui_in, 0);
        checkOutput("reset uio_in", uio_in, 0);
        checkOutput("reset rsp_valid", rsp_valid, 0);
        checkOutput("reset rsp_data", rsp_data, 0);
        checkOutput("reset err_timeout", err_timeout, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset cmd_ready", cmd_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            runVector($sformatf("vec%0d", i), vectors[i]);
        end

        resetMidTransaction();

        for (int i = 0; i < 30; i++) begin
            int r;
            ack_mode_t m;
            r = $urandom_range(0, 9);
            m = (r == 0) ? M_NEVER : (r == 1) ? M_NOOE : (r == 2) ? M_HOLD : M_NORMAL;
            runVector($sformatf("rand%0d", i),
                      refModel(8'($urandom), m, $urandom_range(0, 6), $urandom_range(0, 3)));
        end

        checkOutput("cmd_ready_vs_busy", readyViolations, 0);
        checkOutput("uio_in_upper_bits", pinViolations, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    // Hard stop in case a wait loop misbehaves.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached before test end");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
